// File: rtl/rob_commit_unit.sv
// Reorder buffer feeding the register file: in-order retire onto the commit bus,
// CDB writeback capture, two combinational ready/value searches, flush on mispredicted branch.
module rob_commit_unit #(
  parameter int ROB_WIDTH = 3
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 issue_valid,
  input  logic [4:0]           issue_rd,
  input  logic                 issue_is_br,
  input  logic                 issue_pred_taken,
  input  logic [31:0]          issue_alt_pc,
  output logic [ROB_WIDTH-1:0] issue_rob_id,
  output logic                 rob_full,
  input  logic                 wb_valid,
  input  logic [ROB_WIDTH-1:0] wb_rob_id,
  input  logic [31:0]          wb_val,
  input  logic                 wb_br_taken,
  input  logic [ROB_WIDTH-1:0] search_rob_id_1,
  input  logic [ROB_WIDTH-1:0] search_rob_id_2,
  output logic                 search_ready_1,
  output logic                 search_ready_2,
  output logic [31:0]          search_val_1,
  output logic [31:0]          search_val_2,
  output logic                 commit_ready,
  output logic [4:0]           commit_reg_id,
  output logic [31:0]          commit_val,
  output logic [ROB_WIDTH-1:0] commit_rob_id,
  output logic                 clear,
  output logic [31:0]          clear_pc
);

  localparam int DEPTH = 1 << ROB_WIDTH;

  logic [DEPTH-1:0]     r_busy;
  logic [DEPTH-1:0]     r_ready;
  logic [DEPTH-1:0]     r_mispred;
  logic [DEPTH-1:0]     r_is_br;
  logic [DEPTH-1:0]     r_pred;
  logic [4:0]           r_rd     [DEPTH];
  logic [31:0]          r_val    [DEPTH];
  logic [31:0]          r_alt_pc [DEPTH];
  logic [ROB_WIDTH-1:0] r_head;
  logic [ROB_WIDTH-1:0] r_tail;
  logic [ROB_WIDTH:0]   r_count;

  logic w_issue;
  logic w_wb;
  logic w_commit;
  logic w_flush;
  logic w_byp_1;
  logic w_byp_2;
  logic w_hit_1;
  logic w_hit_2;

  assign rob_full     = (r_count == (ROB_WIDTH+1)'(DEPTH));
  assign issue_rob_id = r_tail;

  // While clear is high the upstream pipeline is being flushed, so its inputs are stale.
  assign w_issue  = issue_valid && !rob_full && !clear;
  assign w_wb     = wb_valid && !clear;
  assign w_commit = r_busy[r_head] && r_ready[r_head];
  assign w_flush  = w_commit && r_is_br[r_head] && r_mispred[r_head];

  assign w_byp_1 = wb_valid && (wb_rob_id == search_rob_id_1);
  assign w_byp_2 = wb_valid && (wb_rob_id == search_rob_id_2);
  assign w_hit_1 = r_busy[search_rob_id_1] && r_ready[search_rob_id_1];
  assign w_hit_2 = r_busy[search_rob_id_2] && r_ready[search_rob_id_2];

  assign search_ready_1 = w_byp_1 || w_hit_1;
  assign search_ready_2 = w_byp_2 || w_hit_2;
  assign search_val_1   = w_byp_1 ? wb_val : (w_hit_1 ? r_val[search_rob_id_1] : 32'd0);
  assign search_val_2   = w_byp_2 ? wb_val : (w_hit_2 ? r_val[search_rob_id_2] : 32'd0);

  // Payload storage; validity is tracked by the busy/ready bits, so no reset is needed here.
  always_ff @(posedge clk_in) begin
    if (!rst_in && rdy_in) begin
      if (w_wb) begin
        r_val[wb_rob_id] <= wb_val;
      end
      if (w_issue) begin
        r_rd[r_tail]     <= issue_rd;
        r_is_br[r_tail]  <= issue_is_br;
        r_pred[r_tail]   <= issue_pred_taken;
        r_alt_pc[r_tail] <= issue_alt_pc;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_head        <= '0;
      r_tail        <= '0;
      r_count       <= '0;
      r_busy        <= '0;
      r_ready       <= '0;
      r_mispred     <= '0;
      commit_ready  <= 1'b0;
      commit_reg_id <= 5'd0;
      commit_val    <= 32'd0;
      commit_rob_id <= '0;
      clear         <= 1'b0;
      clear_pc      <= 32'd0;
    end else if (rdy_in) begin
      commit_ready <= 1'b0;
      clear        <= 1'b0;
      if (w_commit) begin
        commit_ready  <= 1'b1;
        commit_reg_id <= r_rd[r_head];
        commit_val    <= r_val[r_head];
        commit_rob_id <= r_head;
      end
      if (w_flush) begin
        clear     <= 1'b1;
        clear_pc  <= r_alt_pc[r_head];
        r_busy    <= '0;
        r_ready   <= '0;
        r_mispred <= '0;
        r_head    <= '0;
        r_tail    <= '0;
        r_count   <= '0;
      end else begin
        if (w_wb) begin
          r_ready[wb_rob_id]   <= 1'b1;
          r_mispred[wb_rob_id] <= r_is_br[wb_rob_id] && (wb_br_taken != r_pred[wb_rob_id]);
        end
        if (w_commit) begin
          r_busy[r_head]  <= 1'b0;
          r_ready[r_head] <= 1'b0;
          r_head          <= r_head + ROB_WIDTH'(1);
        end
        // Issue is applied last so it wins if it lands on the slot being retired.
        if (w_issue) begin
          r_busy[r_tail]    <= 1'b1;
          r_ready[r_tail]   <= 1'b0;
          r_mispred[r_tail] <= 1'b0;
          r_tail            <= r_tail + ROB_WIDTH'(1);
        end
        case ({w_issue, w_commit})
          2'b10:   r_count <= r_count + (ROB_WIDTH+1)'(1);
          2'b01:   r_count <= r_count - (ROB_WIDTH+1)'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rob_commit_unit.sv
// Self-checking bench for rob_commit_unit: commit scoreboard fed at issue time,
// drained by a negedge monitor, plus per-scenario inline checks.
module tb_rob_commit_unit;

  localparam int RW = 3;

  typedef struct packed {
    logic [4:0]    rd;
    logic [31:0]   val;
    logic [RW-1:0] id;
    logic          clr;
    logic [31:0]   pc;
  } exp_t;

  logic          clk_in = 1'b0;
  logic          rst_in, rdy_in;
  logic          issue_valid, issue_is_br, issue_pred_taken;
  logic [4:0]    issue_rd;
  logic [31:0]   issue_alt_pc;
  logic [RW-1:0] issue_rob_id;
  logic          rob_full;
  logic          wb_valid, wb_br_taken;
  logic [RW-1:0] wb_rob_id;
  logic [31:0]   wb_val;
  logic [RW-1:0] search_rob_id_1, search_rob_id_2;
  logic          search_ready_1, search_ready_2;
  logic [31:0]   search_val_1, search_val_2;
  logic          commit_ready;
  logic [4:0]    commit_reg_id;
  logic [31:0]   commit_val;
  logic [RW-1:0] commit_rob_id;
  logic          clear;
  logic [31:0]   clear_pc;

  exp_t sb[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   last_c  = -1;
  int   prev_c  = -1;
  bit   last_rdy = 1'b0;

  always #5 clk_in = ~clk_in;

  rob_commit_unit #(.ROB_WIDTH(RW)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_is_br(issue_is_br),
    .issue_pred_taken(issue_pred_taken), .issue_alt_pc(issue_alt_pc),
    .issue_rob_id(issue_rob_id), .rob_full(rob_full),
    .wb_valid(wb_valid), .wb_rob_id(wb_rob_id), .wb_val(wb_val), .wb_br_taken(wb_br_taken),
    .search_rob_id_1(search_rob_id_1), .search_rob_id_2(search_rob_id_2),
    .search_ready_1(search_ready_1), .search_ready_2(search_ready_2),
    .search_val_1(search_val_1), .search_val_2(search_val_2),
    .commit_ready(commit_ready), .commit_reg_id(commit_reg_id), .commit_val(commit_val),
    .commit_rob_id(commit_rob_id), .clear(clear), .clear_pc(clear_pc)
  );

  always @(posedge clk_in) begin
    cyc++;
    last_rdy = rdy_in;
  end

  // Outputs only update on edges where rdy_in was high, so only those are scored.
  always @(negedge clk_in) begin
    if (last_rdy && !rst_in) begin
      if (commit_ready) begin
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_commit: got rd=%0d val=%h id=%0d clear=%0b, required no commit",
                   commit_reg_id, commit_val, commit_rob_id, clear);
        end else begin
          mon_e = sb.pop_front();
          if ({commit_reg_id, commit_val, commit_rob_id, clear, clear_pc} !==
              {mon_e.rd, mon_e.val, mon_e.id, mon_e.clr, mon_e.pc}) begin
            n_fail++;
            $display("FAIL commit_data: got rd=%0d val=%h id=%0d clr=%0b pc=%h, required rd=%0d val=%h id=%0d clr=%0b pc=%h",
                     commit_reg_id, commit_val, commit_rob_id, clear, clear_pc,
                     mon_e.rd, mon_e.val, mon_e.id, mon_e.clr, mon_e.pc);
          end
          prev_c = last_c;
          last_c = cyc;
        end
      end else if (clear) begin
        n_tests++;
        n_fail++;
        $display("FAIL clear_without_commit: got clear=1, required 0");
      end
    end
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    sb.delete();
    repeat (2) @(posedge clk_in);
    #1;
    rst_in = 1'b0;
  endtask

  task automatic do_issue(input logic [4:0] rd, input logic br, input logic pred,
                          input logic [31:0] alt);
    issue_valid = 1'b1; issue_rd = rd; issue_is_br = br;
    issue_pred_taken = pred; issue_alt_pc = alt;
    step();
    issue_valid = 1'b0; issue_is_br = 1'b0; issue_pred_taken = 1'b0;
  endtask

  task automatic do_wb(input logic [RW-1:0] id, input logic [31:0] val, input logic taken);
    wb_valid = 1'b1; wb_rob_id = id; wb_val = val; wb_br_taken = taken;
    step();
    wb_valid = 1'b0; wb_br_taken = 1'b0;
  endtask

  task automatic wait_drain(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if ({commit_ready, commit_reg_id, commit_val, commit_rob_id, clear, clear_pc} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got cr=%0b rd=%0d val=%h id=%0d clr=%0b pc=%h, required all 0",
               commit_ready, commit_reg_id, commit_val, commit_rob_id, clear, clear_pc);
    end
    n_tests++;
    if ({rob_full, issue_rob_id, search_ready_1} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got full=%0b tail=%0d sready=%0b, required 0 0 0",
               rob_full, issue_rob_id, search_ready_1);
    end
  endtask

  task automatic test_in_order();
    bit ok;
    sb.push_back('{5'd5, 32'h11, 3'd0, 1'b0, 32'd0});
    do_issue(5'd5, 1'b0, 1'b0, 32'd0);
    sb.push_back('{5'd6, 32'h22, 3'd1, 1'b0, 32'd0});
    do_issue(5'd6, 1'b0, 1'b0, 32'd0);
    do_wb(3'd1, 32'h22, 1'b0);
    do_wb(3'd0, 32'h11, 1'b0);
    wait_drain(ok);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL in_order_drain: got %0d pending, required 0", sb.size());
    end
    n_tests++;
    if (last_c - prev_c !== 1) begin
      n_fail++;
      $display("FAIL in_order_back_to_back: got gap %0d cycles, required 1", last_c - prev_c);
    end
  endtask

  task automatic test_full_wrap();
    bit ok;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      sb.push_back('{5'(i + 1), 32'h100 + 32'(i), 3'(i), 1'b0, 32'd0});
      do_issue(5'(i + 1), 1'b0, 1'b0, 32'd0);
    end
    n_tests++;
    if ({rob_full, issue_rob_id} !== {1'b1, 3'd0}) begin
      n_fail++;
      $display("FAIL full_after_8: got full=%0b tail=%0d, required 1 0", rob_full, issue_rob_id);
    end
    do_issue(5'd31, 1'b0, 1'b0, 32'hDEAD);
    n_tests++;
    if ({rob_full, issue_rob_id} !== {1'b1, 3'd0}) begin
      n_fail++;
      $display("FAIL issue_when_full: got full=%0b tail=%0d, required 1 0", rob_full, issue_rob_id);
    end
    do_wb(3'd0, 32'h100, 1'b0);
    step();
    n_tests++;
    if ({rob_full, issue_rob_id} !== {1'b0, 3'd0}) begin
      n_fail++;
      $display("FAIL after_retire: got full=%0b tail=%0d, required 0 0", rob_full, issue_rob_id);
    end
    sb.push_back('{5'd9, 32'h200, 3'd0, 1'b0, 32'd0});
    do_issue(5'd9, 1'b0, 1'b0, 32'd0);
    n_tests++;
    if ({rob_full, issue_rob_id} !== {1'b1, 3'd1}) begin
      n_fail++;
      $display("FAIL wrap_issue: got full=%0b tail=%0d, required 1 1", rob_full, issue_rob_id);
    end
    for (int i = 1; i < 8; i++) do_wb(3'(i), 32'h100 + 32'(i), 1'b0);
    do_wb(3'd0, 32'h200, 1'b0);
    wait_drain(ok);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL wrap_drain: got %0d pending, required 0", sb.size());
    end
  endtask

  task automatic test_search_bypass();
    bit ok;
    do_reset();
    sb.push_back('{5'd1, 32'h10, 3'd0, 1'b0, 32'd0});
    do_issue(5'd1, 1'b0, 1'b0, 32'd0);
    sb.push_back('{5'd2, 32'h20, 3'd1, 1'b0, 32'd0});
    do_issue(5'd2, 1'b0, 1'b0, 32'd0);
    sb.push_back('{5'd3, 32'hABCD, 3'd2, 1'b0, 32'd0});
    do_issue(5'd3, 1'b0, 1'b0, 32'd0);
    search_rob_id_1 = 3'd2;
    search_rob_id_2 = 3'd0;
    #1;
    n_tests++;
    if ({search_ready_1, search_val_1} !== {1'b0, 32'd0}) begin
      n_fail++;
      $display("FAIL search_not_ready: got rdy=%0b val=%h, required 0 0", search_ready_1, search_val_1);
    end
    wb_valid = 1'b1; wb_rob_id = 3'd2; wb_val = 32'hABCD;
    #1;
    n_tests++;
    if ({search_ready_1, search_val_1} !== {1'b1, 32'hABCD}) begin
      n_fail++;
      $display("FAIL search_bypass: got rdy=%0b val=%h, required 1 0000abcd", search_ready_1, search_val_1);
    end
    n_tests++;
    if ({search_ready_2, search_val_2} !== {1'b0, 32'd0}) begin
      n_fail++;
      $display("FAIL search2_other: got rdy=%0b val=%h, required 0 0", search_ready_2, search_val_2);
    end
    step();
    wb_valid = 1'b0;
    #1;
    n_tests++;
    if ({search_ready_1, search_val_1} !== {1'b1, 32'hABCD}) begin
      n_fail++;
      $display("FAIL search_stored: got rdy=%0b val=%h, required 1 0000abcd", search_ready_1, search_val_1);
    end
    do_wb(3'd0, 32'h10, 1'b0);
    do_wb(3'd1, 32'h20, 1'b0);
    wait_drain(ok);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL search_drain: got %0d pending, required 0", sb.size());
    end
  endtask

  task automatic test_mispredict();
    do_reset();
    sb.push_back('{5'd0, 32'h55, 3'd0, 1'b1, 32'h1000});
    do_issue(5'd0, 1'b1, 1'b0, 32'h1000);
    do_issue(5'd7, 1'b0, 1'b0, 32'd0);
    do_issue(5'd8, 1'b0, 1'b0, 32'd0);
    do_issue(5'd9, 1'b0, 1'b0, 32'd0);
    do_wb(3'd1, 32'h71, 1'b0);
    do_wb(3'd2, 32'h72, 1'b0);
    do_wb(3'd3, 32'h73, 1'b0);
    do_wb(3'd0, 32'h55, 1'b1);
    step();
    n_tests++;
    if ({clear, clear_pc, rob_full, issue_rob_id} !== {1'b1, 32'h1000, 1'b0, 3'd0}) begin
      n_fail++;
      $display("FAIL flush: got clr=%0b pc=%h full=%0b tail=%0d, required 1 00001000 0 0",
               clear, clear_pc, rob_full, issue_rob_id);
    end
    issue_valid = 1'b1; issue_rd = 5'd12;
    wb_valid = 1'b1; wb_rob_id = 3'd0; wb_val = 32'h77;
    step();
    issue_valid = 1'b0; wb_valid = 1'b0;
    search_rob_id_1 = 3'd1;
    #1;
    n_tests++;
    if ({clear, issue_rob_id, search_ready_1} !== {1'b0, 3'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL post_flush: got clr=%0b tail=%0d sready1=%0b, required 0 0 0",
               clear, issue_rob_id, search_ready_1);
    end
    repeat (5) step();
    n_tests++;
    if (sb.size() !== 0) begin
      n_fail++;
      $display("FAIL flush_drain: got %0d pending, required 0", sb.size());
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      sb.push_back('{5'(i + 1), 32'h500 + 32'(i), 3'(i), 1'b0, 32'd0});
      do_issue(5'(i + 1), 1'b0, 1'b0, 32'd0);
    end
    do_wb(3'd0, 32'h500, 1'b0);
    n_tests++;
    if (issue_rob_id !== 3'd4) begin
      n_fail++;
      $display("FAIL b2b_tail_before: got %0d, required 4", issue_rob_id);
    end
    sb.push_back('{5'd5, 32'h504, 3'd4, 1'b0, 32'd0});
    do_issue(5'd5, 1'b0, 1'b0, 32'd0);
    n_tests++;
    if (issue_rob_id !== 3'd5) begin
      n_fail++;
      $display("FAIL b2b_tail_after: got %0d, required 5", issue_rob_id);
    end
    for (int i = 5; i < 8; i++) begin
      sb.push_back('{5'(i + 1), 32'h500 + 32'(i), 3'(i), 1'b0, 32'd0});
      do_issue(5'(i + 1), 1'b0, 1'b0, 32'd0);
    end
    n_tests++;
    if (rob_full !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_count7: got full=%0b, required 0", rob_full);
    end
    sb.push_back('{5'd9, 32'h508, 3'd0, 1'b0, 32'd0});
    do_issue(5'd9, 1'b0, 1'b0, 32'd0);
    n_tests++;
    if (rob_full !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_count8: got full=%0b, required 1", rob_full);
    end
    for (int i = 1; i < 8; i++) do_wb(3'(i), 32'h500 + 32'(i), 1'b0);
    do_wb(3'd0, 32'h508, 1'b0);
    wait_drain(ok);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL b2b_drain: got %0d pending, required 0", sb.size());
    end
  endtask

  task automatic test_stall();
    bit ok;
    do_reset();
    sb.push_back('{5'd10, 32'h3A, 3'd0, 1'b0, 32'd0});
    do_issue(5'd10, 1'b0, 1'b0, 32'd0);
    sb.push_back('{5'd11, 32'h3B, 3'd1, 1'b0, 32'd0});
    do_issue(5'd11, 1'b0, 1'b0, 32'd0);
    do_wb(3'd0, 32'h3A, 1'b0);
    rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++;
      if ({commit_ready, issue_rob_id} !== {1'b0, 3'd2}) begin
        n_fail++;
        $display("FAIL stall_hold: got cr=%0b tail=%0d, required 0 2", commit_ready, issue_rob_id);
      end
    end
    rdy_in = 1'b1;
    step();
    n_tests++;
    if ({commit_ready, commit_rob_id} !== {1'b1, 3'd0}) begin
      n_fail++;
      $display("FAIL stall_resume: got cr=%0b id=%0d, required 1 0", commit_ready, commit_rob_id);
    end
    do_wb(3'd1, 32'h3B, 1'b0);
    wait_drain(ok);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL stall_drain: got %0d pending, required 0", sb.size());
    end
  endtask

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1;
    issue_valid = 1'b0; issue_rd = '0; issue_is_br = 1'b0; issue_pred_taken = 1'b0;
    issue_alt_pc = '0;
    wb_valid = 1'b0; wb_rob_id = '0; wb_val = '0; wb_br_taken = 1'b0;
    search_rob_id_1 = '0; search_rob_id_2 = '0;
    test_reset();
    test_in_order();
    test_full_wrap();
    test_search_bypass();
    test_mispredict();
    test_back_to_back();
    test_stall();
    repeat (2) step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rob_commit_unit.md
Name: rob_commit_unit

Overview:
- Reorder buffer directly upstream of the register file.
- Allocates one entry per issued instruction and collects writeback results from the CDB.
- Answers the register file's two combinational "is ROB entry ready / value" searches.
- Retires in program order, one entry per cycle, onto the commit bus consumed by the register file. Raises the global flush (`clear`) when a mispredicted branch retires.

Parameters:
- ROB_WIDTH, 3, log2 of entry count; depth = 2^ROB_WIDTH.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous active-high reset
- rdy_in  input  1  global ready; all state frozen when low
- issue_valid  input  1  decoder issues one instruction this cycle
- issue_rd  input  5  destination register (0 = none)
- issue_is_br  input  1  entry is a conditional branch
- issue_pred_taken  input  1  predictor decision for the branch
- issue_alt_pc  input  32  PC to redirect to if the branch mispredicts
- issue_rob_id  output  ROB_WIDTH  tail index; the id the next issued entry receives
- rob_full  output  1  count == 2^ROB_WIDTH
- wb_valid  input  1  CDB writeback
- wb_rob_id  input  ROB_WIDTH  entry being completed
- wb_val  input  32  result value
- wb_br_taken  input  1  resolved branch direction (meaningful only for branch entries)
- search_rob_id_1 / search_rob_id_2  input  ROB_WIDTH  entries queried by the register file
- search_ready_1 / search_ready_2  output  1  queried entry is busy and ready
- search_val_1 / search_val_2  output  32  value of the queried entry
- commit_ready  output  1  retire pulse
- commit_reg_id  output  5  retired rd
- commit_val  output  32  retired value
- commit_rob_id  output  ROB_WIDTH  retired index
- clear  output  1  flush pulse
- clear_pc  output  32  redirect PC

Behaviour:
Reset and stall
- Reset: head=tail=count=0; all busy/ready bits 0.
- Reset values of all outputs are 0: commit_ready, commit_reg_id, commit_val, commit_rob_id, clear, clear_pc.
- rdy_in low: no state or output register changes. Consumers gate on rdy_in.

Per-entry state
- busy, ready, rd, val, is_br, pred_taken, alt_pc.
- count is ROB_WIDTH+1 bits wide.
- head and tail wrap modulo 2^ROB_WIDTH.

Issue
- issue_valid && !rob_full && !clear: write entry[tail] with busy=1, ready=0, plus the issue fields; tail++.
- issue_valid while rob_full: ignored. The decoder must stall.

Writeback
- wb_valid && !clear: entry[wb_rob_id].ready=1, val=wb_val.
- For branch entries, also latch mispredict = (wb_br_taken != pred_taken).

Search (combinational)
- search_ready_k = busy && ready of entry[search_rob_id_k], or (wb_valid && wb_rob_id == search_rob_id_k). The second term is a same-cycle CDB bypass.
- search_val_k follows the same priority: bypass first, else the stored val.
- When not ready, search_val_k = 0.

Commit (registered, 1-cycle latency)
- When entry[head] is busy && ready at a clock edge, the next cycle shows commit_ready=1 with rd/val/index of that entry. That entry is freed: busy=0, head++.
- Otherwise commit_ready=0. At most one retire per cycle.
- A ready entry with rd=0 still pulses commit_ready, with commit_reg_id=0.
- Simultaneous issue and commit in one cycle: count unchanged.
- Issue into the slot freed this same cycle is legal only when the ROB is not full at the start of the cycle.

Mispredict
- Retiring a branch with mispredict=1: commit_ready=1 as normal, and in the same cycle clear=1, clear_pc=alt_pc.
- All entries are invalidated; head=tail=count=0 at that edge.
- In the cycle clear is high, issue and writeback inputs are ignored; the next cycle's clear returns to 0.
- A correctly predicted branch retires normally, clear=0.

Wrap
- Head or tail at 2^ROB_WIDTH-1 increments to 0.
- Full and empty are distinguished only by count.

Test Plan:
1. Reset, then issue rd=5 (id0) and rd=6 (id1); writeback id1=0x22, then id0=0x11.
   - Commits must occur in order: (5,0x11,id0), then (6,0x22,id1), on consecutive cycles.
2. Issue 8 entries (ROB_WIDTH=3).
   - rob_full=1; a 9th issue_valid is ignored and tail stays 0.
   - Complete and retire one entry, then issue again: the new entry gets id0 (wrap-around).
3. Hold search_rob_id_1=2 with entry 2 busy and not ready; drive wb_valid, wb_rob_id=2, wb_val=0xABCD.
   - search_ready_1=1 and search_val_1=0xABCD in that same cycle.
   - The next cycle returns the same value from storage.
4. Issue a branch with pred_taken=0, alt_pc=0x1000, followed by 3 ALU entries; writeback the branch with taken=1.
   - On retire: clear=1, clear_pc=0x1000, count=0; the younger entries never commit.
5. With 4 entries queued and the head ready, drive issue_valid in the same cycle as the retire.
   - count stays 4; the new entry gets the old tail id.
6. Drop rdy_in for 3 cycles while the head is ready.
   - No commit during the stall and head is unchanged; the commit occurs on the first cycle after rdy_in returns.
